// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: state encodings, data width and
// bit-timing helper. Optional feature macro: UART_TX_PARITY_EN (adds an
// even-parity bit and widens the state encoding to 3 bits).
package uart_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned BIT_IDX_W = $clog2(DATA_W);

`ifdef UART_TX_PARITY_EN
  localparam int unsigned STATE_W = 3;
  localparam logic [2:0] ST_START  = 3'b000;
  localparam logic [2:0] ST_DATA   = 3'b001;
  localparam logic [2:0] ST_STOP   = 3'b010;
  localparam logic [2:0] ST_IDLE   = 3'b011;
  localparam logic [2:0] ST_PARITY = 3'b100;
`else
  localparam int unsigned STATE_W = 2;
  localparam logic [1:0] ST_START = 2'b00;
  localparam logic [1:0] ST_DATA  = 2'b01;
  localparam logic [1:0] ST_STOP  = 2'b10;
  localparam logic [1:0] ST_IDLE  = 2'b11;
`endif

  // Clocks per serial bit, truncated toward zero.
  function automatic int unsigned clks_per_bit(input int unsigned f, input int unsigned baud);
    return f / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 forever and flags the last
// count with a one-clock tick. Shared between the UART transmitter and
// receiver.
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  output logic tick_c
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  assign tick_c = (count == LAST);

  // Free-running bit-period counter, wraps on the tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (tick_c) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Free-running 8N1 UART transmitter: idle bit, start bit, 8 data bits
// LSB-first, stop bit, repeat. The byte on `data` is captured at each frame
// start. Optional feature macro: UART_TX_PARITY_EN inserts an even-parity
// bit between the data bits and the stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD = 115200,
  parameter int unsigned F    = 50000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  output logic              tx
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(F, BAUD);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_W - 1);

  logic                 tick_c;
  logic [STATE_W-1:0]   state, state_d;
  logic [BIT_IDX_W-1:0] bit_idx, bit_idx_d;
  logic [DATA_W-1:0]    shreg, shreg_d;
  logic                 tx_c;
`ifdef UART_TX_PARITY_EN
  logic                 parity, parity_d;
`endif

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_gen (
    .clk    (clk),
    .rst    (rst),
    .tick_c (tick_c)
  );

  // State, bit index and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      bit_idx <= '0;
      shreg   <= '0;
`ifdef UART_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      bit_idx <= bit_idx_d;
      shreg   <= shreg_d;
`ifdef UART_TX_PARITY_EN
      parity  <= parity_d;
`endif
    end
  end

  // Next-state logic; every transition happens on a bit-period tick.
  always_comb begin
    state_d   = state;
    bit_idx_d = bit_idx;
    shreg_d   = shreg;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity;
`endif
    if (tick_c) begin
      case (state)
        ST_IDLE: begin
          state_d = ST_START;
          shreg_d = data;
`ifdef UART_TX_PARITY_EN
          parity_d = ^data;
`endif
        end
        ST_START: begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
        end
        ST_DATA: begin
          shreg_d   = {1'b0, shreg[DATA_W-1:1]};
          bit_idx_d = bit_idx + BIT_IDX_W'(1);
          if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          state_d = ST_STOP;
        end
`endif
        ST_STOP: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Line level implied by the current state.
  always_comb begin
    tx_c = 1'b1;
    case (state)
      ST_START: tx_c = 1'b0;
      ST_DATA:  tx_c = shreg[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_c = parity;
`endif
      default:  tx_c = 1'b1;
    endcase
  end

  // Pad driver straight from a flop so the line never glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx <= 1'b1;
    end else begin
      tx <= tx_c;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed phases (fixed bytes, mid-frame
// data change, mid-frame reset) followed by random data changes, every
// clock compared against a timeline model of the serial line.
module tb_uart_tx;

  localparam int unsigned BAUD = 115200;
  localparam int unsigned F    = 50000000;
  localparam int unsigned C    = F / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned SLOTS = 12;
`else
  localparam int unsigned SLOTS = 11;
`endif
  localparam int unsigned FRAME = SLOTS * C;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic       tx;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  // Model: non-reset edges since the last reset edge, and the byte latched
  // for the frame in flight.
  int unsigned k = 0;
  logic [7:0]  latched = 8'h00;
  logic        exp_tx;

  uart_tx #(
    .BAUD (BAUD),
    .F    (F)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .data (data),
    .tx   (tx)
  );

  always #5 clk = ~clk;

  // Line level during clock j of a frame timeline (before register delay).
  function automatic logic line_at(input int unsigned j, input logic [7:0] b);
    int unsigned slot;
    slot = (j / C) % SLOTS;
    if (slot == 0) return 1'b1;
    if (slot == 1) return 1'b0;
    if (slot <= 9) return b[3'(slot - 2)];
`ifdef UART_TX_PARITY_EN
    if (slot == 10) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: tx=%b expected %b", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, advance the model at the rising
  // edge, compare shortly after it.
  task automatic cycle(input logic r, input logic [7:0] d);
    @(negedge clk);
    rst  = r;
    data = d;
    @(posedge clk);
    if (r) begin
      exp_tx = 1'b1;
      k      = 0;
    end else begin
      exp_tx = line_at(k, latched);
      k++;
      if ((k % FRAME) == C) latched = d;
    end
    #1;
    check($sformatf("tx k=%0d slot=%0d rst=%0b", k, (k / C) % SLOTS, r), tx, exp_tx);
  endtask

  initial begin
    logic [7:0] rnd;
    int unsigned hold;

    // Reset for 5 clocks.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'hD3);

    // D3 twice, switching to 2C during data bit 4 of the second frame.
    while (k < 3 * FRAME) begin
      if (k >= FRAME + 6 * C) cycle(1'b0, 8'h2C);
      else                    cycle(1'b0, 8'hD3);
    end

    // All-ones byte: only the start bit is low.
    while (k < 4 * FRAME + 6 * C + 200) cycle(1'b0, 8'hFF);

    // One-clock reset pulse in the middle of data bit 4.
    cycle(1'b1, 8'hFF);

    // Parity-sensitive byte for one full frame, then random data changes.
    while (k < FRAME + C) cycle(1'b0, 8'hEF);
    rnd  = 8'($urandom);
    hold = $urandom_range(50, 3000);
    for (int i = 0; i < int'(3 * FRAME); i++) begin
      if (hold == 0) begin
        rnd  = 8'($urandom);
        hold = $urandom_range(50, 3000);
      end else begin
        hold--;
      end
      cycle(1'b0, rnd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Free-running 8N1 UART transmitter. It repeatedly serialises the byte presented on `data` onto the `tx` line: one idle gap, a start bit, 8 data bits LSB-first, then a stop bit, and then the sequence repeats. There is no handshake. `data` is sampled once per frame, so software or upstream logic changes the transmitted byte just by driving `data`. It sits at the chip pin boundary, with `tx` going straight to the pad.

Parameters:
- BAUD, 115200, line bit rate in bits/s.
- F, 50000000, frequency of `clk` in Hz.
- Derived localparam CLKS_PER_BIT = F / BAUD, using integer truncation (434 at defaults). The counter width is $clog2(CLKS_PER_BIT).

Ports:
- clk  in  1  system clock, rising-edge active.
- rst  in  1  reset: synchronous to `clk`, active-high.
- data  in  8  byte to transmit; sampled at each frame start.
- tx  out  1  serial line; idles high and is registered.

Behaviour:
- Single clock domain; every register updates on the rising edge of `clk`.
- Reset is synchronous and active-high. With `rst`=1 at a clock edge:
  - state becomes IDLE, the bit-period counter goes to 0, the bit index goes to 0, and the shift register goes to 0.
  - `tx` is 1 from the next edge onward.
- State encoding is 2 bits: START=2'b00, DATA=2'b01, STOP=2'b10, IDLE=2'b11.
- Bit timer:
  - The counter runs 0 .. CLKS_PER_BIT-1 in every state.
  - A "tick" is counter == CLKS_PER_BIT-1. On a tick the counter wraps to 0.
  - Each state, and each data bit, lasts exactly CLKS_PER_BIT clocks.
- Transitions, all on a tick:
  - IDLE -> START. On this edge `data` is latched into the shift register.
  - START -> DATA, with bit index set to 0.
  - DATA: the shift register shifts right and the bit index increments. After bit index 7 the state goes to STOP.
  - STOP -> IDLE.
- `tx` value per state, registered (one clock of latency from the state change):
  - IDLE = 1
  - START = 0
  - DATA = shift register bit 0
  - STOP = 1
- Frame period is 11 x CLKS_PER_BIT clocks: idle, start, 8 data bits, stop. At defaults this is 4774 clocks.
- Changing `data` mid-frame has no effect on the current frame. Only the value present at the IDLE->START edge is sent.
- The first frame after reset starts after one full IDLE bit period.
- Reset asserted mid-frame aborts the frame immediately. `tx` goes high and a new frame starts from IDLE. No partial bits continue.
- `tx` must be glitch-free, i.e. driven directly from a flop.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - An even-parity bit is inserted between DATA and STOP, in a PARITY state lasting CLKS_PER_BIT clocks.
  - `tx` during PARITY = XOR of the latched byte.
  - State encoding widens to 3 bits.
  - Frame becomes 12 x CLKS_PER_BIT clocks.
- When undefined: 8N1 exactly as above, with no PARITY state and no extra logic.

Decomposition:
- Package uart_pkg holds:
  - the state encodings START/DATA/STOP/IDLE, plus PARITY under the macro;
  - the data width constant 8;
  - a function clks_per_bit(F, BAUD).
- One natural sub-module, uart_baud_gen:
  - parameter CLKS_PER_BIT;
  - inputs clk, rst; output a 1-clock tick pulse.
  - It is shared with a future uart_rx.

Test Plan:
- Reset held for 5 clocks, then released -> `tx`=1 throughout reset and for 434 clocks after release, then falls to 0 (start bit).
- data=8'hD3 held constant -> per 434-clock bit: `tx` = 0 (start), 1,1,0,0,1,0,1,1 (LSB-first), 1 (stop), 1 (idle). The sequence repeats with a period of 4774 clocks.
- data changed from 8'hD3 to 8'h2C midway through the DATA bits -> the current frame completes as D3. The next frame carries 0,0,1,1,0,1,0,0.
- data=8'hFF -> `tx` is low only during the start bit (434 clocks) of each 4774-clock frame.
- rst pulsed for 1 clock during data bit 4 -> `tx` is 1 on the next edge, and the next start bit begins 434 clocks after reset deasserts.
- With UART_TX_PARITY_EN and data=8'hEF -> parity bit = 1, and the frame period is 5208 clocks.
